// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin front end for a UART transmitter,
// with one-cycle launch, optional inter-frame gap and a completion watchdog.
module uart_tx_arbiter #(
    parameter int GAP_CYC = 0,
    parameter int TMO_CYC = 1000000,
    parameter int CW      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic [7:0] data0,
    output logic       rdy0,
    input  logic       valid1,
    input  logic [7:0] data1,
    output logic       rdy1,
    output logic       txstart,
    output logic [7:0] txdin,
    input  logic       txdonetick,
    output logic       busy,
    output logic       owner,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_e;

    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    txdin_q, txdin_d;
    logic          owner_q, owner_d;
    logic          rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic          txstart_q, txstart_d, done_q, done_d, err_q, err_d;
    logic          grant, win, tmo, gap_end;

    // On a tie the requester that did not win last time goes next.
    assign grant   = valid0 | valid1;
    assign win     = (valid0 & valid1) ? ~owner_q : valid1;
    assign tmo     = cnt_q == TMO_LAST;
    assign gap_end = cnt_q == GAP_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            txdin_q   <= '0;
            owner_q   <= 1'b1;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            txstart_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            txdin_q   <= txdin_d;
            owner_q   <= owner_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
            txstart_q <= txstart_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (txdonetick) state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                      else if (tmo) state_d = S_IDLE;
            S_GAP:    if (gap_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txstart_d = state_q == S_IDLE && grant;
        rdy0_d    = txstart_d && !win;
        rdy1_d    = txstart_d && win;
        txdin_d   = txstart_d ? (win ? data1 : data0) : txdin_q;
        owner_d   = txstart_d ? win : owner_q;
        done_d    = state_q == S_WAIT && txdonetick;
        err_d     = state_q == S_WAIT && !txdonetick && tmo;
        // The counter is zero on entry to WAIT and GAP and only runs inside them.
        cnt_d     = ((state_q == S_WAIT && !txdonetick && !tmo) ||
                     (state_q == S_GAP && !gap_end)) ? cnt_q + 1'b1 : '0;
    end

    assign rdy0    = rdy0_q;
    assign rdy1    = rdy1_q;
    assign txstart = txstart_q;
    assign txdin   = txdin_q;
    assign owner   = owner_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiter instances (no gap / long timeout, and gap 5 /
// timeout 8) driven by a grant table plus hand-written gap, watchdog and reset sequences.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       a_rst, a_v0, a_v1, a_tick, a_rdy0, a_rdy1, a_txstart, a_busy, a_owner, a_done, a_err;
    logic [7:0] a_d0, a_d1, a_txdin;
    logic       b_rst, b_v0, b_v1, b_tick, b_rdy0, b_rdy1, b_txstart, b_busy, b_owner, b_done, b_err;
    logic [7:0] b_d0, b_d1, b_txdin;

    uart_tx_arbiter #(.GAP_CYC(0), .TMO_CYC(30), .CW(20)) dut_a (
        .clk(clk), .rst(a_rst), .valid0(a_v0), .data0(a_d0), .rdy0(a_rdy0),
        .valid1(a_v1), .data1(a_d1), .rdy1(a_rdy1), .txstart(a_txstart), .txdin(a_txdin),
        .txdonetick(a_tick), .busy(a_busy), .owner(a_owner), .done(a_done), .err(a_err));

    uart_tx_arbiter #(.GAP_CYC(5), .TMO_CYC(8), .CW(4)) dut_b (
        .clk(clk), .rst(b_rst), .valid0(b_v0), .data0(b_d0), .rdy0(b_rdy0),
        .valid1(b_v1), .data1(b_d1), .rdy1(b_rdy1), .txstart(b_txstart), .txdin(b_txdin),
        .txdonetick(b_tick), .busy(b_busy), .owner(b_owner), .done(b_done), .err(b_err));

    typedef struct {
        logic       v0, v1;
        logic [7:0] d0, d1;
        logic       own;
        logic [7:0] dat;
    } vec_t;
    typedef struct {
        logic       own;
        logic [7:0] dat;
    } exp_t;

    vec_t tbl[8];
    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_a(input logic o, input logic [7:0] d);
        exp_t e;
        e.own = o;
        e.dat = d;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input logic o, input logic [7:0] d);
        exp_t e;
        e.own = o;
        e.dat = d;
        sb_b.push_back(e);
    endtask

    task automatic wait_start_a(input string nm);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (a_txstart === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: txstart not seen within 8 cycles", nm);
    endtask

    task automatic wait_start_b(input string nm);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_txstart === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: txstart not seen within 8 cycles", nm);
    endtask

    // Scoreboards: every launch must match the oldest expected grant.
    always @(negedge clk) begin
        if (a_txstart === 1'b1) begin
            if (sb_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_sb: unexpected txstart txdin=%0h", a_txdin);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_sb_owner", a_owner, e.own);
                chk("a_sb_txdin", a_txdin, e.dat);
                chk("a_sb_rdy", {a_rdy1, a_rdy0}, e.own ? 2 : 1);
            end
        end
    end

    always @(negedge clk) begin
        if (b_txstart === 1'b1) begin
            if (sb_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_sb: unexpected txstart txdin=%0h", b_txdin);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_sb_owner", b_owner, e.own);
                chk("b_sb_txdin", b_txdin, e.dat);
                chk("b_sb_rdy", {b_rdy1, b_rdy0}, e.own ? 2 : 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
        tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
        tbl[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
        tbl[4] = '{1'b0, 1'b1, 8'h33, 8'h44, 1'b1, 8'h44};
        tbl[5] = '{1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 8'h55};
        tbl[6] = '{1'b1, 1'b0, 8'h77, 8'h88, 1'b0, 8'h77};
        tbl[7] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b1, 8'hAA};
        {a_v0, a_v1, a_tick, b_v0, b_v1, b_tick} = '0;
        {a_d0, a_d1, b_d0, b_d1} = '0;
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_owner", a_owner, 1);
        chk("rst_txstart", a_txstart, 0);
        chk("rst_rdy", {a_rdy1, a_rdy0}, 0);
        chk("rst_txdin", a_txdin, 0);
        chk("rst_done_err", {a_done, a_err}, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        // Single request, completion 20 cycles later
        @(negedge clk);
        a_v0 = 1'b1;
        a_d0 = 8'hA5;
        push_a(1'b0, 8'hA5);
        @(negedge clk);
        chk("t1_rdy0", a_rdy0, 1);
        chk("t1_txstart", a_txstart, 1);
        chk("t1_txdin", a_txdin, 8'hA5);
        chk("t1_owner", a_owner, 0);
        a_v0 = 1'b0;
        @(negedge clk);
        chk("t1_rdy0_fall", a_rdy0, 0);
        chk("t1_txstart_fall", a_txstart, 0);
        chk("t1_busy_wait", a_busy, 1);
        repeat (19) @(negedge clk);
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
        chk("t1_done", a_done, 1);
        chk("t1_busy_fall", a_busy, 0);
        @(negedge clk);
        chk("t1_done_pulse", a_done, 0);
        // txdonetick while idle is ignored
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
        chk("idle_tick_done", a_done, 0);
        chk("idle_tick_busy", a_busy, 0);
        // Grant table from a fresh reset
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_v0 = tbl[i].v0;
            a_v1 = tbl[i].v1;
            a_d0 = tbl[i].d0;
            a_d1 = tbl[i].d1;
            push_a(tbl[i].own, tbl[i].dat);
            wait_start_a($sformatf("tbl%0d_start", i));
            chk($sformatf("tbl%0d_owner", i), a_owner, tbl[i].own);
            chk($sformatf("tbl%0d_txdin", i), a_txdin, tbl[i].dat);
            a_v0 = 1'b0;
            a_v1 = 1'b0;
            repeat (3) @(negedge clk);
            a_tick = 1'b1;
            @(negedge clk);
            a_tick = 1'b0;
            chk($sformatf("tbl%0d_done", i), a_done, 1);
        end
        // txdonetick in the very cycle the watchdog would fire
        a_v1 = 1'b1;
        a_d1 = 8'h3C;
        push_a(1'b1, 8'h3C);
        wait_start_a("col_start");
        a_v1 = 1'b0;
        repeat (30) @(negedge clk);
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
        chk("col_done", a_done, 1);
        chk("col_err", a_err, 0);
        @(negedge clk);
        chk("col_err_after", a_err, 0);
        // Reset in the middle of WAIT
        a_v0 = 1'b1;
        a_d0 = 8'h81;
        push_a(1'b0, 8'h81);
        wait_start_a("rw_start");
        a_v0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rw_busy_before", a_busy, 1);
        a_rst = 1'b0;
        #1;
        chk("rw_busy", a_busy, 0);
        chk("rw_owner", a_owner, 1);
        chk("rw_txstart", a_txstart, 0);
        chk("rw_rdy", {a_rdy1, a_rdy0}, 0);
        @(negedge clk);
        a_v0 = 1'b1;
        a_v1 = 1'b1;
        a_d0 = 8'h42;
        a_d1 = 8'h24;
        push_a(1'b0, 8'h42);
        a_rst = 1'b1;
        wait_start_a("rw_regrant");
        chk("rw_regrant_owner", a_owner, 0);
        a_v0 = 1'b0;
        a_v1 = 1'b0;
        // Gap of 5 cycles with both requests held
        b_v0 = 1'b1;
        b_v1 = 1'b1;
        b_d0 = 8'h5A;
        b_d1 = 8'hC3;
        push_b(1'b0, 8'h5A);
        push_b(1'b1, 8'hC3);
        wait_start_b("gap_first");
        @(negedge clk);
        b_tick = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            b_tick = 1'b0;
            if (j == 1) chk("gap_done", b_done, 1);
            if (j <= 5) chk($sformatf("gap_busy_%0d", j), b_busy, 1);
            chk($sformatf("gap_rdy_%0d", j), {b_rdy1, b_rdy0}, (j == 7) ? 2 : 0);
        end
        b_v0 = 1'b0;
        b_v1 = 1'b0;
        // Watchdog on requester 1: err 8 cycles after WAIT entry
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("wd_err_early_%0d", k), b_err, 0);
        end
        @(negedge clk);
        chk("wd_err", b_err, 1);
        chk("wd_owner", b_owner, 1);
        chk("wd_done", b_done, 0);
        chk("wd_busy", b_busy, 0);
        b_v0 = 1'b1;
        b_d0 = 8'h99;
        push_b(1'b0, 8'h99);
        @(negedge clk);
        b_v0 = 1'b0;
        chk("wd_err_pulse", b_err, 0);
        chk("wd_next_grant", b_rdy0, 1);
        repeat (2) @(negedge clk);
        chk("sb_a_left", sb_a.size(), 0);
        chk("sb_b_left", sb_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the UART transmitter. It accepts bytes from two independent producers over a valid/ready handshake and launches each byte into the transmitter with a one-cycle start pulse. It then waits for the transmitter's done tick and enforces an optional inter-frame gap. A watchdog recovers from a transmitter that never reports completion.

Parameters:
GAP_CYC, 0, idle clock cycles inserted after each txdonetick before the next grant (0 = none).
TMO_CYC, 1000000, maximum clock cycles WAIT may last before abort; must be >= 2.
CW, 20, width of the shared gap/timeout counter; must satisfy 2^CW > max(GAP_CYC, TMO_CYC).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
valid0  in  1  requester 0 has a byte; held with data0 stable until rdy0.
data0  in  8  requester 0 byte.
rdy0  out  1  one-cycle pulse: data0 accepted.
valid1  in  1  requester 1 has a byte; held with data1 stable until rdy1.
data1  in  8  requester 1 byte.
rdy1  out  1  one-cycle pulse: data1 accepted.
txstart  out  1  one-cycle start pulse to transmitter.
txdin  out  8  byte to transmitter; stable from LAUNCH until next grant.
txdonetick  in  1  transmitter frame-complete pulse.
busy  out  1  high whenever state is not IDLE.
owner  out  1  requester index of current/last grant.
done  out  1  one-cycle pulse: frame for owner completed.
err  out  1  one-cycle pulse: watchdog abort for owner.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Registered outputs: all outputs are registered.
- Reset values: state IDLE; rdy0 = rdy1 = txstart = done = err = 0; txdin = 0; owner = 1, so requester 0 wins first; counter = 0. busy = 0 (busy decodes state).
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE, grant:
  - If valid0 or valid1 is high, grant at this edge.
  - If only one is valid, that requester wins.
  - If both are valid, the requester != owner wins (strict alternation).
  - At the grant edge: txdin <= winner's data, owner <= winner, winner's rdy <= 1, state <= LAUNCH.
  - If neither is valid, stay in IDLE.
- LAUNCH:
  - Exactly one cycle; the rdy pulse is high during this cycle and deasserts at the next edge.
  - txstart is registered to 1 at the grant edge, so it is high during the LAUNCH cycle only.
  - Next edge: txstart <= 0, counter <= 0, state <= WAIT.
  - Valid inputs are ignored here, so a requester can drop valid or present its next byte in the rdy cycle.
- WAIT:
  - If txdonetick: done <= 1 (one cycle); counter <= 0; state <= GAP if GAP_CYC > 0, else IDLE.
  - Else if counter == TMO_CYC-1: err <= 1 (one cycle); state <= IDLE. No gap after an abort.
  - Else counter increments.
  - txdonetick has priority over timeout in the same cycle.
- GAP: counter increments each cycle; when counter == GAP_CYC-1, state <= IDLE. Requests are not granted during GAP.
- Latencies:
  - Grant to txstart high: 1 cycle, visible in the cycle after the grant edge.
  - txdonetick to next possible grant: GAP_CYC+1 cycles.
  - Back-to-back grant: may occur in the IDLE cycle immediately after done.
- txdonetick outside WAIT is ignored (no done, no state change).
- No counter wrap is permitted: the parameter constraint on CW guarantees it.
- Reset mid-frame forces IDLE immediately. A pending rdy or txstart is cleared with no extra pulse. The requester must re-present its byte.
- A requester dropping valid before its rdy has no effect on an already-captured byte.

Test Plan:
1. Single request: valid0 = 1, data0 = 0xA5 in IDLE. Required: rdy0 high 1 cycle; txstart high the same cycle with txdin = 0xA5 and owner = 0. Then pulse txdonetick 20 cycles later → done pulses 1 cycle; busy falls the next cycle (GAP_CYC = 0).
2. Fairness: valid0 and valid1 both held with data0 = 0x11, data1 = 0x22; each frame completed by txdonetick. Required grant order from reset: 0,1,0,1; txdin sequence 0x11, 0x22, 0x11, 0x22.
3. Gap: GAP_CYC = 5, both requests held. Required: exactly 6 cycles from the txdonetick cycle to the next rdy pulse; no rdy inside GAP.
4. Watchdog: TMO_CYC = 8, grant requester 1, never assert txdonetick. Required: err pulses exactly 8 cycles after WAIT entry, with owner = 1 and no done. The next grant is possible in the following cycle.
5. Collision: txdonetick and timeout in the same cycle. Required: done = 1, err = 0. Also: txdonetick asserted in IDLE produces no done.
6. Reset mid-WAIT: assert rst low for 1 cycle. Required: busy = 0, txstart = rdy0 = rdy1 = 0, and owner = 1 immediately. With both requesters valid after release, requester 0 is granted first.
